pzc_hit_reconstructor: RTL and testbench

Receive-side counterpart of the FPGA hit simulator. It consumes the simulator's pole-zero-corrected sample stream, detects pulses above threshold, and reconstructs one event per pulse: bunch-crossing index, peak amplitude and time-over-threshold. Events are queued in a small FIFO for a valid/ready consumer such as an HPS bridge. Per-orbit occupancy is reported for comparison against the generator's own occupancy count.

---
 rtl/hit_det_pkg.sv | 21 ++
 rtl/hit_event_fifo.sv | 43 ++++
 rtl/pzc_hit_reconstructor.sv | 176 +++++++++++++++++
 tb/tb_pzc_hit_reconstructor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hit_det_pkg.sv
// Shared types and widths for the pulse hit reconstructor.
package hit_det_pkg;

  localparam int TOT_W    = 8;
  localparam int CNT_W    = 16;
  localparam int EV_BT_W  = 13;
  localparam int EV_AMP_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OVER    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  typedef struct packed {
    logic        [EV_BT_W-1:0]  bt;
    logic signed [EV_AMP_W-1:0] amp;
    logic        [TOT_W-1:0]    tot;
  } hit_event_t;

endpackage

// File: rtl/hit_event_fifo.sv
// First-word-fall-through event queue; a push while full is accepted only if a pop happens too.
module hit_event_fifo
  import hit_det_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  hit_event_t din,
  input  logic       pop,
  output hit_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  hit_event_t    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pzc_hit_reconstructor.sv
// Pulse detector/reconstructor for the pole-zero-corrected sample stream.
// Optional running baseline subtraction is compiled in with HIT_DET_BASELINE_EN.
module pzc_hit_reconstructor
  import hit_det_pkg::*;
#(
  parameter int DATA_W     = 30,
  parameter int BT_W       = 13,
  parameter int BT_PERIOD  = 3564,
  parameter int THRESHOLD  = 1024,
  parameter int HOLDOFF    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BL_SHIFT   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     bt_sync,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [BT_W-1:0]          ev_bt,
  output logic signed [DATA_W-1:0] ev_amp,
  output logic [TOT_W-1:0]         ev_tot,
  output logic [CNT_W-1:0]         occupancy,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [BT_W-1:0]          BT_MAX = BT_W'(BT_PERIOD - 1);
  localparam logic signed [DATA_W-1:0] THR    = DATA_W'(THRESHOLD);

  logic                     s1_valid;
  logic signed [DATA_W-1:0] s1_sample, x, base;
  logic [BT_W-1:0]          s1_bt, bt_cnt, bt_cur;
  logic                     over, wrap;

  state_t                   state, state_n;
  logic signed [DATA_W-1:0] peak, peak_n;
  logic [BT_W-1:0]          peak_bt, peak_bt_n;
  logic [TOT_W-1:0]         tot, tot_n;
  logic [HOLD_W-1:0]        hold, hold_n;
  logic                     wr;

  hit_event_t               head;
  logic                     fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]         occ_cnt;

  // bt_cnt is the index the next valid sample will receive
  assign bt_cur = bt_sync ? '0 : bt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sample <= '0;
      s1_bt     <= '0;
      bt_cnt    <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_sample <= sample_in;
        s1_bt     <= bt_cur;
        bt_cnt    <= (bt_cur == BT_MAX) ? '0 : bt_cur + BT_W'(1);
      end
    end
  end

  assign x    = s1_sample - base;
  assign over = (x > THR);
  assign wrap = s1_valid && (s1_bt == BT_MAX);

`ifdef HIT_DET_BASELINE_EN
  logic signed [DATA_W-1:0] base_n;
  assign base_n = base + ((s1_sample - base) >>> BL_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          base <= '0;
    else if (s1_valid && state == ST_IDLE && !over)   base <= base_n;
  end
`else
  assign base = '0;
  if (BL_SHIFT < 0) begin : g_bl_shift_range
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      peak    <= '0;
      peak_bt <= '0;
      tot     <= '0;
      hold    <= '0;
    end else begin
      state   <= state_n;
      peak    <= peak_n;
      peak_bt <= peak_bt_n;
      tot     <= tot_n;
      hold    <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    peak_n    = peak;
    peak_bt_n = peak_bt;
    tot_n     = tot;
    hold_n    = hold;
    wr        = 1'b0;
    if (s1_valid) begin
      unique case (state)
        ST_IDLE: if (over) begin
          state_n   = ST_OVER;
          peak_n    = x;
          peak_bt_n = s1_bt;
          tot_n     = TOT_W'(1);
        end
        ST_OVER: if (over) begin
          if (tot != '1) tot_n = tot + TOT_W'(1);
          // strict compare keeps the first of equal maxima
          if (x > peak) begin
            peak_n    = x;
            peak_bt_n = s1_bt;
          end
        end else begin
          wr = 1'b1;
          if (HOLDOFF == 0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_HOLDOFF;
            hold_n  = HOLD_W'(HOLDOFF);
          end
        end
        ST_HOLDOFF: begin
          hold_n = hold - HOLD_W'(1);
          if (hold <= HOLD_W'(1)) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign pop = ev_valid && ev_ready;

  hit_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .din   ('{bt: EV_BT_W'(peak_bt), amp: EV_AMP_W'(peak), tot: tot}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_bt    = fifo_empty ? '0 : BT_W'(head.bt);
  assign ev_amp   = fifo_empty ? '0 : DATA_W'(head.amp);
  assign ev_tot   = fifo_empty ? '0 : head.tot;

  // an event finalized on the wrap cycle belongs to the orbit being closed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_cnt   <= '0;
      occupancy <= '0;
      drop_cnt  <= '0;
    end else begin
      if (wrap) begin
        occupancy <= occ_cnt + CNT_W'(wr);
        occ_cnt   <= '0;
      end else if (wr) begin
        occ_cnt <= occ_cnt + CNT_W'(1);
      end
      if (wr && fifo_full && !pop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pzc_hit_reconstructor.sv
// Scoreboard bench: stimulus queues hand-computed events, a negedge monitor checks each pop.
module tb_pzc_hit_reconstructor;

  localparam int DATA_W = 30;
  localparam int BT_W   = 13;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic signed [DATA_W-1:0] sample_in = '0;
  logic                     sample_valid = 1'b0;
  logic                     bt_sync = 1'b0;
  logic                     ev_valid;
  logic                     ev_ready = 1'b1;
  logic [BT_W-1:0]          ev_bt;
  logic signed [DATA_W-1:0] ev_amp;
  logic [7:0]               ev_tot;
  logic [15:0]              occupancy;
  logic [15:0]              drop_cnt;

  typedef struct {
    int bt;
    int amp;
    int tot;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pzc_hit_reconstructor #(
    .DATA_W(DATA_W), .BT_W(BT_W), .BT_PERIOD(64), .THRESHOLD(1024),
    .HOLDOFF(4), .FIFO_DEPTH(4), .BL_SHIFT(6)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .bt_sync(bt_sync), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_bt(ev_bt),
    .ev_amp(ev_amp), .ev_tot(ev_tot), .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endfunction

  function automatic void expect_ev(input int bt, input int amp, input int tot);
    exp_t e;
    e.bt = bt; e.amp = amp; e.tot = tot;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got bt=%0d amp=%0d tot=%0d expected none", ev_bt, ev_amp, ev_tot);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ev_bt",  longint'(ev_bt),  longint'(e.bt));
        chk("ev_amp", longint'(ev_amp), longint'(e.amp));
        chk("ev_tot", longint'(ev_tot), longint'(e.tot));
      end
    end
  end

  task automatic drive(input int s, input bit sync = 1'b0, input bit v = 1'b1);
    sample_in    = DATA_W'(s);
    sample_valid = v;
    bt_sync      = sync;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    bt_sync      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ev_valid",  ev_valid,  0);
    chk("reset_ev_amp",    ev_amp,    0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_drop_cnt",  drop_cnt,  0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // orbit 0: basic pulse (sync on the first sample) and flat top
    expect_ev(2, 5000, 3);
    drive(0, 1'b1);
    drive(2000); drive(5000); drive(3000); drive(500);
    chk("latency_not_yet", ev_valid, 0);
    drive(0);
    chk("latency_ev_valid", ev_valid, 1);
    idle(5);
    expect_ev(12, 4000, 3);
    drive(2000); drive(4000); drive(4000); drive(100);
    idle(6);
    idle(43);
    drive(0);
    chk("occupancy_orbit0", occupancy, 2);

    // orbit 1: six pulses with consumer stalled -> four queued, two dropped
    ev_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p < 4) expect_ev(1 + 7 * p, 3000 + p, 1);
      drive(3000 + p);
      drive(0);
      idle(5);
    end
    chk("drop_cnt_full", drop_cnt, 2);
    chk("ev_valid_held", ev_valid, 1);
    idle(21);
    drive(0);
    chk("occupancy_orbit1", occupancy, 6);

    // orbit 2: write into a full FIFO coinciding with a pop is kept
    expect_ev(1, 3100, 1);
    drive(3100);
    drive(0);
    ev_ready = 1'b1;
    drive(0);
    chk("drop_cnt_pop_write", drop_cnt, 2);
    idle(58);
    // pulse terminating on the last bunch of the orbit
    expect_ev(62, 2800, 1);
    drive(2800);
    drive(0);
    drive(0);
    chk("occupancy_wrap_event", occupancy, 2);

    // orbit 3: sample_valid gaps inside a pulse freeze the detector
    idle(4);
    expect_ev(6, 2600, 2);
    drive(2500);
    drive(0, 1'b0, 1'b0); drive(0, 1'b0, 1'b0); drive(0, 1'b0, 1'b0);
    drive(2600);
    drive(100);
    idle(8);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("drop_cnt_final", drop_cnt, 2);

`ifdef HIT_DET_BASELINE_EN
    ev_ready = 1'b0;
    for (int i = 0; i < 1000; i++) drive(512);
    chk("baseline_settle_no_event", ev_valid, 0);
    drive(512 + 3000);
    drive(512);
    idle(2);
    chk("baseline_event_valid", ev_valid, 1);
    chk_range("baseline_event_amp", longint'(ev_amp), 2990, 3070);
    chk("baseline_event_tot", ev_tot, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
